// File: rtl/mandel_pkg.sv
// Shared definitions for the pixel<->complex mappers: fixed-point format,
// screen geometry defaults and the mapper state encoding.
package mandel_pkg;
   localparam int DEF_WORD_LENGTH   = 32;
   localparam int DEF_FRAC          = 28;
   localparam int DEF_SCREEN_WIDTH  = 640;
   localparam int DEF_SCREEN_HEIGHT = 480;
   localparam int COORD_W           = 11;

   typedef logic signed [DEF_WORD_LENGTH-1:0] fixed_t;

   typedef enum logic [2:0] {IDLE, SETUP, DIV_X, DIV_Y, DONE} state_t;
endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// The caller guarantees num < den * 2**QBITS, so only QBITS quotient bits exist.
module seq_divider #(
   parameter int NUM_W = 44,
   parameter int DEN_W = 33,
   parameter int QBITS = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic             busy,
   output logic             done,
   output logic [QBITS-1:0] quotient
);
   localparam int CNT_W = $clog2(QBITS + 1);

   logic [DEN_W-1:0] rem, den_r, rem_nxt;
   logic [QBITS-1:0] lo, q;
   logic [CNT_W-1:0] count;
   logic [DEN_W:0]   trial;
   logic             ge;

   always_comb begin
      trial   = {rem, lo[QBITS-1]};
      ge      = trial >= {1'b0, den_r};
      rem_nxt = ge ? DEN_W'(trial - {1'b0, den_r}) : trial[DEN_W-1:0];
   end

   // done is asserted during the last iteration; quotient is final then
   assign busy     = count != '0;
   assign done     = count == CNT_W'(1);
   assign quotient = {q[QBITS-2:0], ge};

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         rem   <= '0;
         den_r <= '0;
         lo    <= '0;
         q     <= '0;
      end else if (start) begin
         rem   <= num[NUM_W-1 -: DEN_W];
         lo    <= num[QBITS-1:0];
         den_r <= den;
         q     <= '0;
         count <= CNT_W'(QBITS);
      end else if (busy) begin
         rem   <= rem_nxt;
         lo    <= lo << 1;
         q     <= quotient;
         count <= count - CNT_W'(1);
      end
   end
endmodule

// File: rtl/complex_to_pixel.sv
// Maps a complex point back to the screen pixel it falls in under the current view.
//   state | meaning
//   IDLE  | waiting for a request, in_ready=1
//   SETUP | view extents, offsets and on-screen test from the captured request
//   DIV_X | column = dx*SCREEN_WIDTH/real_width on the shared divider
//   DIV_Y | row    = dy*SCREEN_HEIGHT/imag_height on the shared divider
//   DONE  | result valid, held until out_ready
module complex_to_pixel
   import mandel_pkg::*;
#(
   parameter int WORD_LENGTH   = DEF_WORD_LENGTH,
   parameter int FRAC          = DEF_FRAC,
   parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WORD_LENGTH-1:0] re_in,
   input  logic [WORD_LENGTH-1:0] im_in,
   input  logic [31:0]            ZOOM,
   input  logic [WORD_LENGTH-1:0] real_center,
   input  logic [WORD_LENGTH-1:0] imag_center,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [COORD_W-1:0]     x,
   output logic [COORD_W-1:0]     y,
   output logic                   on_screen
);
   localparam int EXT_W = WORD_LENGTH + 1;
   localparam int NUM_W = EXT_W + COORD_W;
   localparam logic signed [WORD_LENGTH-1:0] REAL_SPAN = WORD_LENGTH'(3) << FRAC;
   localparam logic signed [WORD_LENGTH-1:0] IMAG_SPAN = WORD_LENGTH'(2) << FRAC;
   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_HEIGHT - 1);

   state_t state, state_nxt;

   logic signed [WORD_LENGTH-1:0] re_r, im_r, rc_r, ic_r;
   logic [31:0]                   zoom_r;
   logic signed [WORD_LENGTH-1:0] real_width, imag_height, real_min, imag_max;
   logic [EXT_W-1:0]              dx, dy;
   logic                          on;
   logic                          div_start, div_busy, div_done;
   logic [NUM_W-1:0]              div_num;
   logic [EXT_W-1:0]              div_den;
   logic [COORD_W-1:0]            div_q, q_limit, q_clamped;

   // offsets carry one extra bit so extreme operands cannot wrap
   always_comb begin
      if (zoom_r >= 32'(WORD_LENGTH)) begin
         real_width  = '0;
         imag_height = '0;
      end else begin
         real_width  = REAL_SPAN >>> zoom_r;
         imag_height = IMAG_SPAN >>> zoom_r;
      end
      real_min = rc_r - (real_width >>> 1);
      imag_max = ic_r + (imag_height >>> 1);
      dx = {re_r[WORD_LENGTH-1], re_r} - {real_min[WORD_LENGTH-1], real_min};
      dy = {imag_max[WORD_LENGTH-1], imag_max} - {im_r[WORD_LENGTH-1], im_r};
      on = (real_width != '0) && (imag_height != '0)
           && !dx[EXT_W-1] && (dx < {1'b0, real_width})
           && !dy[EXT_W-1] && (dy < {1'b0, imag_height});
   end

   always_comb begin
      if (state == SETUP) begin
         div_num = {{COORD_W{1'b0}}, dx} * NUM_W'(SCREEN_WIDTH);
         div_den = {1'b0, real_width};
      end else begin
         div_num = {{COORD_W{1'b0}}, dy} * NUM_W'(SCREEN_HEIGHT);
         div_den = {1'b0, imag_height};
      end
      q_limit   = (state == DIV_X) ? X_MAX : Y_MAX;
      q_clamped = (div_q > q_limit) ? q_limit : div_q;
   end

   seq_divider #(
      .NUM_W (NUM_W),
      .DEN_W (EXT_W),
      .QBITS (COORD_W)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .num      (div_num),
      .den      (div_den),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_q)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = SETUP;
         SETUP:   state_nxt = on ? DIV_X : DONE;
         DIV_X:   if (div_done)  state_nxt = DIV_Y;
         DIV_Y:   if (div_done)  state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // the y division is launched on the same edge the x quotient is taken
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      div_start = ((state == SETUP) && on && !div_busy) || ((state == DIV_X) && div_done);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         re_r      <= '0;
         im_r      <= '0;
         rc_r      <= '0;
         ic_r      <= '0;
         zoom_r    <= '0;
         x         <= '0;
         y         <= '0;
         on_screen <= 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            re_r   <= re_in;
            im_r   <= im_in;
            rc_r   <= real_center;
            ic_r   <= imag_center;
            zoom_r <= ZOOM;
         end
         if (state == SETUP) begin
            on_screen <= on;
            if (!on) begin
               x <= '0;
               y <= '0;
            end
         end
         if ((state == DIV_X) && div_done) x <= q_clamped;
         if ((state == DIV_Y) && div_done) y <= q_clamped;
      end
   end
endmodule

// File: tb/tb_complex_to_pixel.sv
// Bench for complex_to_pixel: hand-derived vector table, handshake/reset
// sequences, then random requests against an arithmetic reference model.
module tb_complex_to_pixel;
   localparam int  FRAC = 28;
   localparam int  SW   = 640;
   localparam int  SH   = 480;
   localparam int  RC   = -134217728;

   typedef struct {
      int          re;
      int          im;
      int unsigned zoom;
      int          rc;
      int          ic;
      int          ex;
      int          ey;
      bit          eon;
      int          elat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, on_screen;
   logic [31:0] re_in, im_in, ZOOM, real_center, imag_center;
   logic [10:0] x, y;

   int n_vec  = 0;
   int n_miss = 0;

   complex_to_pixel dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .re_in       (re_in),
      .im_in       (im_in),
      .ZOOM        (ZOOM),
      .real_center (real_center),
      .imag_center (imag_center),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .x           (x),
      .y           (y),
      .on_screen   (on_screen)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t model(input vec_t v);
      vec_t   r;
      longint w, h, rmin, imax, dx, dy;
      bit     on;
      r    = v;
      w    = (v.zoom >= 32) ? 0 : (longint'(3) << FRAC) >> v.zoom;
      h    = (v.zoom >= 32) ? 0 : (longint'(2) << FRAC) >> v.zoom;
      rmin = longint'(v.rc) - w / 2;
      imax = longint'(v.ic) + h / 2;
      dx   = longint'(v.re) - rmin;
      dy   = imax - longint'(v.im);
      on   = (w > 0) && (h > 0) && (dx >= 0) && (dx < w) && (dy >= 0) && (dy < h);
      r.eon  = on;
      r.ex   = on ? int'(dx * SW / w) : 0;
      r.ey   = on ? int'(dy * SH / h) : 0;
      r.elat = on ? 24 : 2;
      return r;
   endfunction

   // One request: latency counted in cycles from the accept cycle (cycle 0)
   task automatic apply(input vec_t v, input bit hold);
      int lat;
      bit seen;
      @(negedge clk);
      check("in_ready_idle", in_ready, 1);
      in_valid    = 1'b1;
      re_in       = v.re;
      im_in       = v.im;
      ZOOM        = v.zoom;
      real_center = v.rc;
      imag_center = v.ic;
      @(negedge clk);
      in_valid    = 1'b0;
      re_in       = $urandom;
      im_in       = $urandom;
      ZOOM        = $urandom;
      real_center = $urandom;
      imag_center = $urandom;
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat < 100) begin
         if (out_valid) seen = 1'b1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      if (!seen) begin
         check("timeout", 0, 1);
         return;
      end
      check("latency", lat, v.elat);
      check("x", x, v.ex);
      check("y", y, v.ey);
      check("on_screen", on_screen, v.eon);
      check("in_ready_busy", in_ready, 0);
      if (hold) begin
         out_ready = 1'b0;
         repeat (10) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_x", x, v.ex);
            check("hold_y", y, v.ey);
            check("hold_on", on_screen, v.eon);
         end
         out_ready = 1'b1;
      end
      @(negedge clk);
      check("valid_drop", out_valid, 0);
      check("in_ready_back", in_ready, 1);
   endtask

   vec_t tbl[$];
   vec_t v;
   int   rw, ih;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      re_in = '0; im_in = '0; ZOOM = '0; real_center = '0; imag_center = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      check("rst_on", on_screen, 0);

      //            re          im         zoom rc  ic  x    y    on  lat
      tbl.push_back('{-536870912, 268435456, 0, RC, 0, 0,   0,   1'b1, 24});
      tbl.push_back('{-134217728, 0,         0, RC, 0, 320, 240, 1'b1, 24});
      tbl.push_back('{268435456,  0,         0, RC, 0, 0,   0,   1'b0, 2});
      tbl.push_back('{-671088640, 0,         0, RC, 0, 0,   0,   1'b0, 2});
      tbl.push_back('{268435455, -268435455, 0, RC, 0, 639, 479, 1'b1, 24});
      tbl.push_back('{-134217728, -268435456, 0, RC, 0, 0,  0,   1'b0, 2});
      tbl.push_back('{-134217728, 0,        40, RC, 0, 0,   0,   1'b0, 2});
      tbl.push_back('{0,          0,         2, 0,  0, 320, 240, 1'b1, 24});
      foreach (tbl[i]) apply(tbl[i], 1'b0);

      apply(tbl[1], 1'b1);

      // reset while the x division is in flight
      @(negedge clk);
      in_valid = 1'b1; re_in = tbl[4].re; im_in = tbl[4].im;
      ZOOM = 0; real_center = RC; imag_center = 0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_valid", out_valid, 0);
      check("midrst_ready", in_ready, 1);
      check("midrst_x", x, 0);
      check("midrst_on", on_screen, 0);
      apply(tbl[1], 1'b0);

      for (int i = 0; i < 300; i++) begin
         v.zoom = ($urandom_range(0, 9) == 0) ? $urandom_range(28, 40) : $urandom_range(0, 6);
         v.rc   = int'($urandom_range(0, 1 << 27)) - (1 << 26);
         v.ic   = int'($urandom_range(0, 1 << 27)) - (1 << 26);
         rw     = (v.zoom >= 32) ? 0 : (3 << FRAC) >> v.zoom;
         ih     = (v.zoom >= 32) ? 0 : (2 << FRAC) >> v.zoom;
         v.re   = v.rc - rw + int'($urandom_range(0, 2 * rw));
         v.im   = v.ic - ih + int'($urandom_range(0, 2 * ih));
         v      = model(v);
         apply(v, ($urandom_range(0, 15) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/complex_to_pixel.md
Name: complex_to_pixel

Overview:
Inverse of the pixel→complex mapping. Takes a complex point (re, im) plus the current view (ZOOM, centres) and returns the screen pixel (x, y) it falls in, or flags it off-screen. Used for overlays such as orbit plots and markers, and for checking the forward mapper. It sits beside the pixel→complex mapper, uses the same Q(WORD_LENGTH-FRAC).FRAC format, and uses valid/ready handshakes on both sides.

Parameters:
WORD_LENGTH, 32, fixed-point word width (signed).
FRAC, 28, fractional bits.
SCREEN_WIDTH, 640, horizontal pixels (≤2048).
SCREEN_HEIGHT, 480, vertical pixels (≤2048).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
re_in  in  WORD_LENGTH  real part, signed Qm.FRAC
im_in  in  WORD_LENGTH  imaginary part, signed Qm.FRAC
ZOOM  in  32  zoom shift count
real_center  in  WORD_LENGTH  view centre, real part, signed
imag_center  in  WORD_LENGTH  view centre, imaginary part, signed
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
x  out  11  pixel column
y  out  11  pixel row
on_screen  out  1  1 = point lies inside the view

Behaviour:
- Reset: state IDLE; in_ready=1 after reset; out_valid=0; x=0; y=0; on_screen=0. A reset mid-operation aborts the operation and discards the request.
- Accept: in_valid&in_ready (cycle 0) captures re_in, im_in, ZOOM, real_center, imag_center. Inputs that change later are ignored. in_ready = (state==IDLE).
- SETUP (cycle 1) computes:
  - real_width = (3<<FRAC)>>>ZOOM; imag_height = (2<<FRAC)>>>ZOOM. Any ZOOM ≥ WORD_LENGTH gives 0.
  - real_min = real_center − (real_width>>>1); imag_max = imag_center + (imag_height>>>1).
  - dx = re − real_min; dy = imag_max − im. Both are computed at WORD_LENGTH+1 bits, so there is no wrap.
  - on = (real_width≠0) & (imag_height≠0) & (0≤dx<real_width) & (0≤dy<imag_height).
- If on=0: go to DONE; out_valid at cycle 2 with x=y=0, on_screen=0.
- If on=1:
  - DIV_X, 11 cycles (cycles 2..12): x = floor(dx·SCREEN_WIDTH / real_width).
  - DIV_Y, 11 cycles (cycles 13..23): y = floor(dy·SCREEN_HEIGHT / imag_height).
  - DONE: out_valid=1 at cycle 24, on_screen=1.
  - Division is restoring, 1 quotient bit per cycle, MSB first. The numerator is (WORD_LENGTH+1+11) bits unsigned and the remainder is WORD_LENGTH+1 bits.
  - Because dx<real_width, the quotient is <SCREEN_WIDTH, so 11 bits always suffice.
  - Results are clamped to SCREEN_WIDTH−1 / SCREEN_HEIGHT−1 as a safety measure; the clamp is never reached for legal inputs.
- DONE: x, y, on_screen are held stable while out_valid=1 and out_ready=0. On out_valid&out_ready the block goes to IDLE, out_valid=0 next cycle and in_ready=1 next cycle. x/y keep their last values.
- No request overlap: throughput is one result per 25 cycles (on-screen) or 3 cycles (off-screen), plus back-pressure time.
- Rounding is exact floor. The forward mapper accumulates a truncated step, so a round-trip may differ by ±1 pixel; this is documented, not a bug.

Decomposition:
- mandel_pkg: WORD_LENGTH, FRAC, SCREEN_WIDTH/HEIGHT defaults, COORD_W=11, typedef fixed_t (signed WORD_LENGTH), and the state enum {IDLE, SETUP, DIV_X, DIV_Y, DONE}. The package is shared with the pixel→complex mapper.
- One sub-module, seq_divider: start/busy/done handshake, parameterised numerator/denominator widths, QBITS=11. It is instantiated once and reused for x then y.

Test Plan:
Common setup: FRAC=28, 640×480, ZOOM=0, real_center=−134217728 (−0.5), imag_center=0. This gives real_min=−536870912, imag_max=268435456.
1. re=−536870912, im=268435456 → out_valid at cycle 24, x=0, y=0, on_screen=1.
2. re=−134217728, im=0 → x=320, y=240, on_screen=1.
3. re=268435456 (dx=width) → on_screen=0, x=y=0, out_valid at cycle 2. Same result for re=−671088640 (−2.5).
4. Hold out_ready=0 for 10 cycles after case 2 → outputs stable, in_ready=0. Raise out_ready → in_ready=1 the next cycle.
5. ZOOM=40 → width 0 → on_screen=0. ZOOM=2, centre 0 → re=0,im=0 gives x=320, y=240.
6. Assert rst during DIV_X → out_valid=0 and in_ready=1 after reset. A fresh request then completes correctly.
